// File: rtl/apb_ctrl_pkg.sv
// Shared types and constants for the two-requester APB master.
// Holds the bus FSM state type, slave count and default timeout.
package apb_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int NSLV        = 4;
  localparam int TIMEOUT_DEF = 15;

  // One-hot slave select from the two address MSBs.
  function automatic logic [NSLV-1:0] slave_sel(input logic [1:0] idx);
    logic [NSLV-1:0] sel;
    sel      = '0;
    sel[idx] = 1'b1;
    return sel;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; grant is combinational, history advances on update.
// After reset req0 wins the first contention.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid0,
  input  logic       valid1,
  input  logic       update,
  output logic [1:0] grant
);

  // 1 means requester 1 was granted most recently.
  logic last_grant_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_reg <= 1'b1;
    end else if (update) begin
      last_grant_reg <= grant[1];
    end
  end

  assign grant[0] = valid0 & (~valid1 | last_grant_reg);
  assign grant[1] = valid1 & (~valid0 | ~last_grant_reg);

endmodule

// File: rtl/apb_master_arb.sv
// APB master shared by two requesters through a round-robin arbiter.
// Every output is a register; ACCESS ends on PREADY or after TIMEOUT wait cycles.
module apb_master_arb
  import apb_ctrl_pkg::*;
#(
  parameter int DWIDTH  = 8,
  parameter int AWIDTH  = 8,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [AWIDTH-1:0] req0_addr,
  input  logic [DWIDTH-1:0] req0_wdata,
  output logic              req0_grant,
  output logic              req0_done,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [AWIDTH-1:0] req1_addr,
  input  logic [DWIDTH-1:0] req1_wdata,
  output logic              req1_grant,
  output logic              req1_done,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [AWIDTH-1:0] PADDR,
  output logic              PWRITE,
  output logic [DWIDTH-1:0] PWDATA,
  output logic [NSLV-1:0]   PSEL,
  output logic              PENABLE,
  input  logic [DWIDTH-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  apb_state_t        state_reg, state_next;
  logic [NSLV-1:0]   psel_reg, psel_next;
  logic              penable_reg, penable_next;
  logic [AWIDTH-1:0] paddr_reg, paddr_next;
  logic              pwrite_reg, pwrite_next;
  logic [DWIDTH-1:0] pwdata_reg, pwdata_next;
  logic [1:0]        grant_reg, grant_next;
  logic [1:0]        done_reg, done_next;
  logic [DWIDTH-1:0] rdata_reg, rdata_next;
  logic              err_reg, err_next;
  logic [CW-1:0]     wait_cnt_reg, wait_cnt_next;
  logic              owner_reg, owner_next;

  logic [1:0]        arb_grant;
  logic              arb_update;
  logic [AWIDTH-1:0] win_addr;

  rr_arb2 u_arb (
    .clk    (PCLK),
    .rst    (PRESET),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .update (arb_update),
    .grant  (arb_grant)
  );

  assign win_addr = arb_grant[1] ? req1_addr : req0_addr;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_reg    <= IDLE;
      psel_reg     <= '0;
      penable_reg  <= 1'b0;
      paddr_reg    <= '0;
      pwrite_reg   <= 1'b0;
      pwdata_reg   <= '0;
      grant_reg    <= '0;
      done_reg     <= '0;
      rdata_reg    <= '0;
      err_reg      <= 1'b0;
      wait_cnt_reg <= '0;
      owner_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      psel_reg     <= psel_next;
      penable_reg  <= penable_next;
      paddr_reg    <= paddr_next;
      pwrite_reg   <= pwrite_next;
      pwdata_reg   <= pwdata_next;
      grant_reg    <= grant_next;
      done_reg     <= done_next;
      rdata_reg    <= rdata_next;
      err_reg      <= err_next;
      wait_cnt_reg <= wait_cnt_next;
      owner_reg    <= owner_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    psel_next     = psel_reg;
    penable_next  = penable_reg;
    paddr_next    = paddr_reg;
    pwrite_next   = pwrite_reg;
    pwdata_next   = pwdata_reg;
    grant_next    = '0;
    done_next     = '0;
    rdata_next    = '0;
    err_next      = 1'b0;
    wait_cnt_next = wait_cnt_reg;
    owner_next    = owner_reg;
    arb_update    = 1'b0;

    unique case (state_reg)
      IDLE: begin
        psel_next    = '0;
        penable_next = 1'b0;
        if (arb_grant != 2'b00) begin
          arb_update    = 1'b1;
          owner_next    = arb_grant[1];
          grant_next    = arb_grant;
          paddr_next    = win_addr;
          pwrite_next   = arb_grant[1] ? req1_write : req0_write;
          pwdata_next   = arb_grant[1] ? req1_wdata : req0_wdata;
          psel_next     = slave_sel(win_addr[AWIDTH-1 -: 2]);
          wait_cnt_next = '0;
          state_next    = SETUP;
        end
      end

      SETUP: begin
        penable_next = 1'b1;
        state_next   = ACCESS;
      end

      ACCESS: begin
        // PREADY on the last allowed cycle still counts as a normal completion.
        if (PREADY) begin
          done_next[owner_reg] = 1'b1;
          rdata_next           = pwrite_reg ? '0 : PRDATA;
          err_next             = PSLVERR;
          psel_next            = '0;
          penable_next         = 1'b0;
          state_next           = IDLE;
        end else if (wait_cnt_reg == CW'(TIMEOUT - 1)) begin
          done_next[owner_reg] = 1'b1;
          err_next             = 1'b1;
          psel_next            = '0;
          penable_next         = 1'b0;
          state_next           = IDLE;
        end else begin
          wait_cnt_next = wait_cnt_reg + CW'(1);
        end
      end

      default: begin
        state_next   = IDLE;
        psel_next    = '0;
        penable_next = 1'b0;
      end
    endcase
  end

  assign req0_grant = grant_reg[0];
  assign req1_grant = grant_reg[1];
  assign req0_done  = done_reg[0];
  assign req1_done  = done_reg[1];
  assign rsp_rdata  = rdata_reg;
  assign rsp_err    = err_reg;
  assign PADDR      = paddr_reg;
  assign PWRITE     = pwrite_reg;
  assign PWDATA     = pwdata_reg;
  assign PSEL       = psel_reg;
  assign PENABLE    = penable_reg;

endmodule
